// File: rtl/wb_trace_fifo_if.sv
// Writeback capture and trace drain signals for wb_trace_fifo.
// The master side drives writebacks and consumes the trace stream.
interface wb_trace_fifo_if;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [11:0] wb_pc;
  logic        trace_valid;
  logic        trace_ready;
  logic [11:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;

  modport master (
    output wb_en, wb_reg, wb_data, wb_pc, trace_ready,
    input  trace_valid, trace_pc, trace_reg, trace_data
  );

  modport slave (
    input  wb_en, wb_reg, wb_data, wb_pc, trace_ready,
    output trace_valid, trace_pc, trace_reg, trace_data
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures regfile writes as {pc, reg, data} records and
// drains them first-word-fall-through over valid/ready, counting overflow drops.
module wb_trace_fifo #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  wb_trace_fifo_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [11:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } rec_t;

  rec_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [LVL_W-1:0] level_r, level_nxt_s;
  logic [CNT_W-1:0] drop_cnt_r, drop_cnt_nxt_s;
  logic             overflow_r, overflow_nxt_s;
  logic             valid_r, valid_nxt_s;
  rec_t             head_r, head_nxt_s, wb_rec_s;
  logic             push_req_s, pop_s, push_s, drop_s;

  // Handshake qualification and next-state computation for pointers, level, counters and head.
  always_comb begin
    wb_rec_s       = '{pc: bus.wb_pc, rg: bus.wb_reg, data: bus.wb_data};
    push_req_s     = bus.wb_en & ~((DROP_R0 == 1'b1) & (bus.wb_reg == 5'd0));
    pop_s          = valid_r & bus.trace_ready;
    push_s         = push_req_s & ((level_r < LVL_W'(DEPTH)) | pop_s);
    drop_s         = push_req_s & ~push_s;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    level_nxt_s    = level_r;
    drop_cnt_nxt_s = drop_cnt_r;
    overflow_nxt_s = overflow_r;
    head_nxt_s     = head_r;

    if (clear) begin
      wr_ptr_nxt_s   = '0;
      rd_ptr_nxt_s   = '0;
      level_nxt_s    = '0;
      drop_cnt_nxt_s = '0;
      overflow_nxt_s = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        level_nxt_s = level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
        level_nxt_s = level_r - LVL_W'(1);
      end else begin
        level_nxt_s = level_r;
      end
      if (drop_s) begin
        overflow_nxt_s = 1'b1;
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_nxt_s = drop_cnt_r + CNT_W'(1);
        end else begin
          drop_cnt_nxt_s = drop_cnt_r;
        end
      end else begin
        overflow_nxt_s = overflow_r;
        drop_cnt_nxt_s = drop_cnt_r;
      end
      // The new head slot is still being written this edge when it equals wr_ptr; bypass it.
      if (level_nxt_s != '0) begin
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
          head_nxt_s = wb_rec_s;
        end else begin
          head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
      end else begin
        head_nxt_s = head_r;
      end
    end
    valid_nxt_s = (level_nxt_s != '0);
  end

  // Control state and registered trace outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      drop_cnt_r <= '0;
      overflow_r <= 1'b0;
      valid_r    <= 1'b0;
      head_r     <= '0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      level_r    <= level_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
      overflow_r <= overflow_nxt_s;
      valid_r    <= valid_nxt_s;
      head_r     <= head_nxt_s;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_s && !clear) begin
      mem_r[wr_ptr_r] <= wb_rec_s;
    end
  end

  assign bus.trace_valid = valid_r;
  assign bus.trace_pc    = head_r.pc;
  assign bus.trace_reg   = head_r.rg;
  assign bus.trace_data  = head_r.data;
  assign level           = level_r;
  assign overflow        = overflow_r;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [11:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } rec_t;

  typedef struct {
    logic        en;
    logic [4:0]  rg;
    logic [31:0] data;
    logic [11:0] pc;
    logic        clr;
    logic        rdy;
    logic        x_valid;
    logic [3:0]  x_level;
    logic [11:0] x_pc;
    logic [4:0]  x_reg;
    logic [31:0] x_data;
    logic [7:0]  x_drop;
    logic        x_ovf;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       clear;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clear0;
  logic [3:0] level0;
  logic       overflow0;
  logic [7:0] drop_cnt0;

  wb_trace_fifo_if bus ();
  wb_trace_fifo_if bus0 ();

  wb_trace_fifo #(.DEPTH(8), .CNT_W(8), .DROP_R0(1'b1)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  wb_trace_fifo #(.DEPTH(8), .CNT_W(8), .DROP_R0(1'b0)) dut0 (
    .clock(clock), .reset(reset), .clear(clear0), .bus(bus0),
    .level(level0), .overflow(overflow0), .drop_cnt(drop_cnt0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  rec_t mq[$];
  int   m_drop;
  bit   m_ovf;
  rec_t m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_last = '0;
  endtask

  // Reference behaviour for one clock edge, from the pre-edge model state.
  task automatic model_step(input logic en, input logic [4:0] r, input logic [31:0] d,
                            input logic [11:0] p, input logic clr, input logic rdy);
    int   sz;
    bit   pop;
    rec_t rec;
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    rec = '{pc: p, rg: r, data: d};
    if (clr) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (en && (r != 5'd0)) begin
        if (sz < DEPTH || pop) mq.push_back(rec);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic step(input logic en, input logic [4:0] r, input logic [31:0] d,
                      input logic [11:0] p, input logic clr, input logic rdy);
    bus.wb_en       = en;
    bus.wb_reg      = r;
    bus.wb_data     = d;
    bus.wb_pc       = p;
    bus.trace_ready = rdy;
    clear           = clr;
    model_step(en, r, d, p, clr, rdy);
    @(posedge clock);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 64'(bus.trace_valid), 64'(mq.size() != 0));
    check({tag, ".level"}, 64'(level), 64'(mq.size()));
    check({tag, ".drop"},  64'(drop_cnt), 64'(m_drop));
    check({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    check({tag, ".pc"},    64'(bus.trace_pc), 64'(m_last.pc));
    check({tag, ".reg"},   64'(bus.trace_reg), 64'(m_last.rg));
    check({tag, ".data"},  64'(bus.trace_data), 64'(m_last.data));
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 5'(i % 31 + 1), base + 32'(i), 12'(i * 4), 1'b0, 1'b0);
      compare_all("fill");
    end
  endtask

  vec_t        vecs[8];
  logic [31:0] last_seen;
  logic        en_r;
  logic [4:0]  reg_r;
  logic        rdy_r;
  logic        clr_r;
  int          phase;

  initial begin
    vecs[0] = '{1'b1, 5'd1, 32'h11, 12'h004, 1'b0, 1'b1, 1'b1, 4'd1, 12'h004, 5'd1, 32'h11, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 5'd2, 32'h22, 12'h008, 1'b0, 1'b1, 1'b1, 4'd1, 12'h008, 5'd2, 32'h22, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 5'd0, 32'h00, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0, 12'h008, 5'd2, 32'h22, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 5'd0, 32'h33, 12'h00C, 1'b0, 1'b1, 1'b0, 4'd0, 12'h008, 5'd2, 32'h22, 8'd0, 1'b0};
    vecs[4] = '{1'b1, 5'd3, 32'h44, 12'h010, 1'b0, 1'b0, 1'b1, 4'd1, 12'h010, 5'd3, 32'h44, 8'd0, 1'b0};
    vecs[5] = '{1'b1, 5'd4, 32'h55, 12'h014, 1'b0, 1'b0, 1'b1, 4'd2, 12'h010, 5'd3, 32'h44, 8'd0, 1'b0};
    vecs[6] = '{1'b0, 5'd0, 32'h00, 12'h000, 1'b0, 1'b1, 1'b1, 4'd1, 12'h014, 5'd4, 32'h55, 8'd0, 1'b0};
    vecs[7] = '{1'b1, 5'd6, 32'h66, 12'h018, 1'b1, 1'b1, 1'b0, 4'd0, 12'h014, 5'd4, 32'h55, 8'd0, 1'b0};

    reset = 1'b0;
    clear = 1'b0;
    clear0 = 1'b0;
    bus.wb_en = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0; bus.wb_pc = 12'd0; bus.trace_ready = 1'b0;
    bus0.wb_en = 1'b0; bus0.wb_reg = 5'd0; bus0.wb_data = 32'd0; bus0.wb_pc = 12'd0; bus0.trace_ready = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].en, vecs[i].rg, vecs[i].data, vecs[i].pc, vecs[i].clr, vecs[i].rdy);
      check($sformatf("vec%0d.valid", i), 64'(bus.trace_valid), 64'(vecs[i].x_valid));
      check($sformatf("vec%0d.level", i), 64'(level), 64'(vecs[i].x_level));
      check($sformatf("vec%0d.pc", i),    64'(bus.trace_pc), 64'(vecs[i].x_pc));
      check($sformatf("vec%0d.reg", i),   64'(bus.trace_reg), 64'(vecs[i].x_reg));
      check($sformatf("vec%0d.data", i),  64'(bus.trace_data), 64'(vecs[i].x_data));
      check($sformatf("vec%0d.drop", i),  64'(drop_cnt), 64'(vecs[i].x_drop));
      check($sformatf("vec%0d.ovf", i),   64'(overflow), 64'(vecs[i].x_ovf));
    end

    // Register 0 is recorded when the filter is disabled.
    bus0.wb_en = 1'b1; bus0.wb_reg = 5'd0; bus0.wb_data = 32'h5A; bus0.wb_pc = 12'h010;
    @(posedge clock);
    #1;
    bus0.wb_en = 1'b0;
    check("r0_keep.valid", 64'(bus0.trace_valid), 64'd1);
    check("r0_keep.level", 64'(level0), 64'd1);
    check("r0_keep.reg",   64'(bus0.trace_reg), 64'd0);
    check("r0_keep.data",  64'(bus0.trace_data), 64'h5A);
    check("r0_keep.pc",    64'(bus0.trace_pc), 64'h010);

    // Nine pushes into an eight-deep FIFO, then drain.
    step(1'b0, 5'd0, 32'd0, 12'd0, 1'b1, 1'b0);
    fill(9, 32'h100);
    check("ovf.level", 64'(level), 64'd8);
    check("ovf.drop",  64'(drop_cnt), 64'd1);
    check("ovf.flag",  64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf.drain%0d", i), 64'(bus.trace_data), 64'(32'h100 + 32'(i)));
      step(1'b0, 5'd0, 32'd0, 12'd0, 1'b0, 1'b1);
      compare_all("ovf_drain");
    end
    check("ovf.empty", 64'(bus.trace_valid), 64'd0);

    // Full FIFO with simultaneous push and pop.
    step(1'b0, 5'd0, 32'd0, 12'd0, 1'b1, 1'b0);
    fill(8, 32'h200);
    step(1'b1, 5'd7, 32'hAB, 12'h0F0, 1'b0, 1'b1);
    compare_all("fullpp");
    check("fullpp.level", 64'(level), 64'd8);
    check("fullpp.drop",  64'(drop_cnt), 64'd0);
    last_seen = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.trace_valid) last_seen = bus.trace_data;
      step(1'b0, 5'd0, 32'd0, 12'd0, 1'b0, 1'b1);
    end
    check("fullpp.last", 64'(last_seen), 64'hAB);
    check("fullpp.empty", 64'(bus.trace_valid), 64'd0);

    // Drop counter saturation, then clear coincident with a push.
    fill(8, 32'h300);
    for (int i = 0; i < 260; i++) step(1'b1, 5'd9, 32'(i), 12'h100, 1'b0, 1'b0);
    compare_all("sat");
    check("sat.drop", 64'(drop_cnt), 64'hFF);
    step(1'b1, 5'd9, 32'h77, 12'h104, 1'b1, 1'b0);
    check("clr.level", 64'(level), 64'd0);
    check("clr.drop",  64'(drop_cnt), 64'd0);
    check("clr.ovf",   64'(overflow), 64'd0);
    check("clr.valid", 64'(bus.trace_valid), 64'd0);
    step(1'b0, 5'd0, 32'd0, 12'd0, 1'b0, 1'b0);
    compare_all("clr_after");

    // Asynchronous reset with five records stored.
    fill(5, 32'h400);
    check("rst.pre_level", 64'(level), 64'd5);
    #2;
    reset = 1'b0;
    #1;
    check("rst.valid", 64'(bus.trace_valid), 64'd0);
    check("rst.level", 64'(level), 64'd0);
    model_reset();
    compare_all("rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 5'd9, 32'hCAFE, 12'h0AC, 1'b0, 1'b0);
    compare_all("rst_push");
    check("rst_push.valid", 64'(bus.trace_valid), 64'd1);
    check("rst_push.data",  64'(bus.trace_data), 64'hCAFE);

    // Randomized traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 200) % 3;
      en_r  = ($urandom_range(0, 3) != 0);
      reg_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case (phase)
        0:       rdy_r = ($urandom_range(0, 3) == 0);
        1:       rdy_r = ($urandom_range(0, 3) != 0);
        default: rdy_r = ($urandom_range(0, 1) == 0);
      endcase
      clr_r = ($urandom_range(0, 199) == 0);
      step(en_r, reg_r, $urandom, 12'($urandom), clr_r, rdy_r);
      compare_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
